// File: rtl/seq_magnitude_comparator_pkg.sv
// -----------------------------------------------------------------------------
// seq_cmp_pkg
// Shared types and elaboration helpers for the iterative magnitude comparator.
//   state_e   : controller states (IDLE, SCAN, DONE)
//   cmp_dims_t: digit count and digit-index width derived from WIDTH/DIGIT
// Optional build macro used by the comparator: SEQ_CMP_EARLY_EXIT_EN.
// -----------------------------------------------------------------------------
package seq_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    int unsigned ndig;   // number of DIGIT-bit slices in an operand
    int unsigned idx_w;  // width of the digit index counter (at least 1)
  } cmp_dims_t;

  // Derives the digit count and the index width from the operand geometry.
  function automatic cmp_dims_t cmp_dims(input int unsigned width,
                                         input int unsigned digit);
    cmp_dims_t d;
    d.ndig  = width / digit;
    d.idx_w = (d.ndig > 32'd1) ? unsigned'($clog2(d.ndig)) : 32'd1;
    return d;
  endfunction

endpackage

// File: rtl/seq_magnitude_comparator_cmp_digit.sv
// -----------------------------------------------------------------------------
// cmp_digit
// Combinational unsigned comparator for one DIGIT-bit slice.
// Ports:
//   x, y : digit slices of operand A and operand B
//   gt   : x > y
//   lt   : x < y
// -----------------------------------------------------------------------------
module cmp_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             gt,
  output logic             lt
);

  assign gt = (x > y);
  assign lt = (x < y);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// seq_magnitude_comparator
// Iterative WIDTH-bit magnitude comparator. Operands are scanned MSB-first,
// DIGIT bits per clock, through a single digit-slice comparator. Signed
// compares are done by flipping the sign bit of both operands (offset binary)
// and comparing unsigned.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   start        : request, accepted whenever not busy (IDLE or DONE)
//   signed_mode  : sampled with start, 1 = two's-complement compare
//   a, b         : operands, sampled with start
//   busy         : high while scanning
//   done         : one-cycle pulse, results valid
//   a_gt_b, a_lt_b, a_eq_b : registered results, held until next accept
// Build option:
//   SEQ_CMP_EARLY_EXIT_EN : finish on the first unequal digit instead of
//                           always scanning all NDIG digits.
// -----------------------------------------------------------------------------
module seq_magnitude_comparator
  import seq_cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b
);

  localparam cmp_dims_t DIMS  = cmp_dims(WIDTH, DIGIT);
  localparam int        NDIG  = int'(DIMS.ndig);
  localparam int        IDX_W = int'(DIMS.idx_w);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             res_gt_q, res_gt_d;
  logic             res_lt_q, res_lt_d;
  logic             res_eq_q, res_eq_d;

  logic [DIGIT-1:0] dig_a_s, dig_b_s;
  logic             dig_gt_s, dig_lt_s;
  logic             last_s, hit_s, finish_s;
  logic [WIDTH-1:0] msb_s;

  // Digit-slice mux: OR of masked slices, selected by the digit index.
  always_comb begin
    dig_a_s = '0;
    dig_b_s = '0;
    for (int i = 0; i < NDIG; i++) begin
      dig_a_s = dig_a_s | (a_q[i*DIGIT +: DIGIT] & {DIGIT{idx_q == IDX_W'(i)}});
      dig_b_s = dig_b_s | (b_q[i*DIGIT +: DIGIT] & {DIGIT{idx_q == IDX_W'(i)}});
    end
  end

  cmp_digit #(
    .DIGIT (DIGIT)
  ) u_cmp_digit (
    .x  (dig_a_s),
    .y  (dig_b_s),
    .gt (dig_gt_s),
    .lt (dig_lt_s)
  );

  assign last_s = (idx_q == '0);
  // First unequal digit seen while no decision has been made yet.
  assign hit_s  = !(gt_q | lt_q) && (dig_gt_s | dig_lt_s);

`ifdef SEQ_CMP_EARLY_EXIT_EN
  assign finish_s = last_s | hit_s;
`else
  assign finish_s = last_s;
`endif

  // Next-state, operand capture, digit scan and result update.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    gt_d     = gt_q;
    lt_d     = lt_q;
    res_gt_d = res_gt_q;
    res_lt_d = res_lt_q;
    res_eq_d = res_eq_q;
    msb_s    = '0;
    msb_s[WIDTH-1] = signed_mode;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = SCAN;
          a_d      = a ^ msb_s;
          b_d      = b ^ msb_s;
          idx_d    = IDX_LAST;
          gt_d     = 1'b0;
          lt_d     = 1'b0;
          res_gt_d = 1'b0;
          res_lt_d = 1'b0;
          res_eq_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        // Once a decision exists, lower digits no longer matter.
        if (hit_s) begin
          gt_d = dig_gt_s;
          lt_d = dig_lt_s;
        end else begin
          gt_d = gt_q;
          lt_d = lt_q;
        end
        if (finish_s) begin
          state_d  = DONE;
          res_gt_d = gt_d;
          res_lt_d = lt_d;
          res_eq_d = !(gt_d | lt_d);
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, operand, index and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
      res_gt_q <= 1'b0;
      res_lt_q <= 1'b0;
      res_eq_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
      res_gt_q <= res_gt_d;
      res_lt_q <= res_lt_d;
      res_eq_q <= res_eq_d;
    end
  end

  assign busy   = (state_q == SCAN);
  assign done   = (state_q == DONE);
  assign a_gt_b = res_gt_q;
  assign a_lt_b = res_lt_q;
  assign a_eq_b = res_eq_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// tb_seq_magnitude_comparator
// Directed self-checking bench with a result scoreboard. Expected results and
// latencies come from a behavioural model (native signed/unsigned compares).
// Optional build macro honoured: SEQ_CMP_EARLY_EXIT_EN.
// -----------------------------------------------------------------------------
module tb_seq_magnitude_comparator;

  typedef struct {
    logic gt;
    logic lt;
    logic eq;
    int   lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        signed_mode;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy, done, a_gt_b, a_lt_b, a_eq_b;

  // Second instance covering WIDTH == DIGIT
  logic        s_start;
  logic        s_sm;
  logic [1:0]  s_a;
  logic [1:0]  s_b;
  logic        s_busy, s_done, s_gt, s_lt, s_eq;

  exp_t sb_q[$];
  int   n_assert  = 0;
  int   n_fail    = 0;
  int   acc_cyc   = 0;
  int   busy_cnt  = 0;
  int   cyc_total = 0;

  always #5 clk = ~clk;

  seq_magnitude_comparator #(.WIDTH(16), .DIGIT(2)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .a_gt_b      (a_gt_b),
    .a_lt_b      (a_lt_b),
    .a_eq_b      (a_eq_b)
  );

  seq_magnitude_comparator #(.WIDTH(2), .DIGIT(2)) u_dut_w2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (s_start),
    .signed_mode (s_sm),
    .a           (s_a),
    .b           (s_b),
    .busy        (s_busy),
    .done        (s_done),
    .a_gt_b      (s_gt),
    .a_lt_b      (s_lt),
    .a_eq_b      (s_eq)
  );

  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic sm);
    exp_t        e;
    logic [15:0] x;
    logic        found;
    if (sm) begin
      e.gt = ($signed(ma) > $signed(mb));
      e.lt = ($signed(ma) < $signed(mb));
    end else begin
      e.gt = (ma > mb);
      e.lt = (ma < mb);
    end
    e.eq  = (ma == mb);
    e.lat = 8;
    found = 1'b0;
    x     = 16'h0000;
`ifdef SEQ_CMP_EARLY_EXIT_EN
    for (int k = 1; k <= 8; k++) begin
      x = (ma ^ mb) >> ((8 - k) * 2);
      if (!found && (x[1:0] != 2'b00)) begin
        e.lat = k;
        found = 1'b1;
      end
    end
`endif
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    acc_cyc++;
    cyc_total++;
    if (busy === 1'b1) busy_cnt++;
  endtask

  task automatic start_op(input logic [15:0] oa, input logic [15:0] ob, input logic sm);
    start       = 1'b1;
    a           = oa;
    b           = ob;
    signed_mode = sm;
    sb_q.push_back(model(oa, ob, sm));
    tick();
    start    = 1'b0;
    acc_cyc  = 0;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      while (done !== 1'b1 && acc_cyc < 40) tick();
      check({tag, "_latency"}, acc_cyc, e.lat);
      check({tag, "_busy_cycles"}, busy_cnt, e.lat);
      check({tag, "_result"}, {a_gt_b, a_lt_b, a_eq_b}, {e.gt, e.lt, e.eq});
    end
  endtask

  initial begin
    int   d1;
    logic done_seen;
    exp_t dropped;

    rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a = 16'h0000; b = 16'h0000;
    s_start = 1'b0; s_sm = 1'b0; s_a = 2'b00; s_b = 2'b00;
    tick(); tick();
    check("reset_outputs", {busy, done, a_gt_b, a_lt_b, a_eq_b}, 5'b00000);
    check("reset_outputs_w2", {s_busy, s_done, s_gt, s_lt, s_eq}, 5'b00000);
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", {busy, done}, 2'b00);

    // Equal operands
    start_op(16'h1234, 16'h1234, 1'b0);
    check("eq_busy_after_accept", busy, 1'b1);
    wait_done("eq_1234");

    // Mode checks
    start_op(16'h8000, 16'h0001, 1'b0);
    wait_done("mode_unsigned");
    start_op(16'h8000, 16'h0001, 1'b1);
    wait_done("mode_signed");
    start_op(16'hFFFF, 16'hFFFE, 1'b1);
    wait_done("mode_signed_neg");

    // Data-dependent exit point, then result hold after done
    start_op(16'h00FF, 16'h0100, 1'b0);
    wait_done("early_exit");
    tick();
    check("hold_done_low", done, 1'b0);
    check("hold_result", {a_gt_b, a_lt_b, a_eq_b}, 3'b010);

    // Start while busy is ignored
    start_op(16'h0005, 16'h0003, 1'b0);
    tick(); tick();
    start = 1'b1; a = 16'h0001; b = 16'h0009;
    tick();
    start = 1'b0;
    wait_done("start_while_busy");

    // Back-to-back: start held through the DONE cycle
    start_op(16'h0003, 16'h0002, 1'b0);
    tick();
    start = 1'b1; a = 16'h0000; b = 16'h0000; signed_mode = 1'b0;
    sb_q.push_back(model(16'h0000, 16'h0000, 1'b0));
    wait_done("b2b_first");
    d1 = cyc_total;
    tick();
    start    = 1'b0;
    acc_cyc  = 0;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    check("b2b_accepted", busy, 1'b1);
    wait_done("b2b_second");
    check("b2b_gap", cyc_total - d1, 9);

    // Asynchronous reset mid-scan
    start_op(16'h1234, 16'h1235, 1'b0);
    tick(); tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {busy, done, a_gt_b, a_lt_b, a_eq_b}, 5'b00000);
    dropped = sb_q.pop_front();
    done_seen = 1'b0;
    tick(); done_seen = done_seen | done;
    tick(); done_seen = done_seen | done;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      done_seen = done_seen | done;
    end
    check("no_done_after_reset", done_seen, 1'b0);
    check("idle_after_mid_reset", {busy, a_gt_b, a_lt_b, a_eq_b}, 4'b0000);
    start_op(16'hABCD, 16'h1234, 1'b1);
    wait_done("after_reset");

    // WIDTH == DIGIT: single SCAN cycle
    s_start = 1'b1; s_a = 2'b10; s_b = 2'b01; s_sm = 1'b1;
    tick();
    s_start = 1'b0;
    check("w2_busy", {s_busy, s_done}, 2'b10);
    tick();
    check("w2_done", {s_busy, s_done}, 2'b01);
    check("w2_signed_result", {s_gt, s_lt, s_eq}, 3'b010);
    s_start = 1'b1; s_sm = 1'b0;
    tick();
    s_start = 1'b0;
    tick();
    check("w2_unsigned_result", {s_done, s_gt, s_lt, s_eq}, 4'b1100);

    check("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
